// File: rtl/base64_to_ascii_dec.sv
// base64_to_ascii_dec: BASE64 character stream to packed OUT_W-bit ASCII decoder.
// Define BASE64_URL_EN to also accept the URL-safe '-' and '_' characters.
module base64_to_ascii_dec #(
   parameter int OUT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       in_char,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_ascii,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err,
   output logic [3:0]       bit_cnt
);
   localparam int BW = OUT_W + 5;
   localparam logic [3:0] OW = 4'(OUT_W);
   logic [BW-1:0] sh_q, sh_d, ins;
   logic [3:0] cnt_q, cnt_d;
   logic err_q, err_d;
   logic up, lo, dg, plus, slash, pad, legal, acc, emit;
   logic alt62, alt63;
   logic [5:0] idx;
`ifdef BASE64_URL_EN
   assign alt62 = in_char == 7'h2D;
   assign alt63 = in_char == 7'h5F;
`else
   assign alt62 = 1'b0;
   assign alt63 = 1'b0;
`endif
   assign in_ready  = cnt_q < OW;
   assign out_valid = !in_ready;
   assign out_ascii = sh_q[BW-1 -: OUT_W];
   assign err       = err_q;
   assign bit_cnt   = cnt_q;
   always_comb begin
      up    = in_char >= 7'h41 && in_char <= 7'h5A;
      lo    = in_char >= 7'h61 && in_char <= 7'h7A;
      dg    = in_char >= 7'h30 && in_char <= 7'h39;
      plus  = in_char == 7'h2B || alt62;
      slash = in_char == 7'h2F || alt63;
      pad   = in_char == 7'h3D;
      legal = up || lo || dg || plus || slash;
      idx   = up ? 6'(in_char - 7'h41) : lo ? 6'(in_char - 7'h47) :
              dg ? 6'(in_char + 7'h04) : plus ? 6'd62 : 6'd63;
      // held bits stay MSB-aligned, so a new sextet lands just below them
      ins   = {idx, {(BW-6){1'b0}}} >> cnt_q;
      acc   = in_valid && in_ready;
      emit  = out_valid && out_ready;
      sh_d  = emit ? sh_q << OUT_W : (acc && pad) ? '0 : (acc && legal) ? sh_q | ins : sh_q;
      cnt_d = emit ? cnt_q - OW : (acc && pad) ? 4'd0 : (acc && legal) ? cnt_q + 4'd6 : cnt_q;
      err_d = err_q || (acc && !pad && !legal);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_base64_to_ascii_dec.sv
// tb_base64_to_ascii_dec: directed self-checking bench for base64_to_ascii_dec.
module tb_base64_to_ascii_dec;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] in_char = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [6:0] out_ascii;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       err;
   logic [3:0] bit_cnt;
   int checks = 0;
   int errors = 0;
   logic [6:0] msg [14] = '{7'h43, 7'h4F, 7'h4D, 7'h50, 7'h33, 7'h31, 7'h31,
                            7'h5F, 7'h69, 7'h73, 7'h5F, 7'h66, 7'h75, 7'h6E};

   base64_to_ascii_dec #(.OUT_W(7)) dut (
      .clk(clk), .rst(rst), .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready),
      .out_ascii(out_ascii), .out_valid(out_valid), .out_ready(out_ready),
      .err(err), .bit_cnt(bit_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] b64(input logic [5:0] v);
      return v < 26 ? 7'(65 + v) : v < 52 ? 7'(71 + v) : v < 62 ? 7'(v - 4) : v == 62 ? 7'h2B : 7'h2F;
   endfunction

   // Inputs change 1 time unit after a rising edge; outputs are read there too.
   task automatic send(input logic [6:0] c);
      int n = 0;
      in_char = c;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL send_timeout char=%h in_ready=%b required 1", c, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks += 5;
      if (bit_cnt !== 4'd0) begin errors++; $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); end
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      if (out_ascii !== 7'h00) begin errors++; $display("FAIL reset_out_ascii got %h want 00", out_ascii); end
   endtask

   task automatic test_basic();
      send(7'h68);
      checks += 2;
      if (bit_cnt !== 4'd6) begin errors++; $display("FAIL basic_h_cnt got %0d want 6", bit_cnt); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_h_valid got %b want 0", out_valid); end
      send(7'h7A);
      checks += 4;
      if (bit_cnt !== 4'd12) begin errors++; $display("FAIL basic_z_cnt got %0d want 12", bit_cnt); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_z_valid got %b want 1", out_valid); end
      if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_z_ready got %b want 0", in_ready); end
      if (out_ascii !== 7'h43) begin errors++; $display("FAIL basic_z_ascii got %h want 43", out_ascii); end
      pop();
      checks += 3;
      if (bit_cnt !== 4'd5) begin errors++; $display("FAIL basic_pop_cnt got %0d want 5", bit_cnt); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_pop_ready got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %b want 0", out_valid); end
   endtask

   task automatic test_pad();
      send(7'h3D);
      checks += 3;
      if (bit_cnt !== 4'd0) begin errors++; $display("FAIL pad_cnt got %0d want 0", bit_cnt); end
      if (err !== 1'b0) begin errors++; $display("FAIL pad_err got %b want 0", err); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL pad_valid got %b want 0", out_valid); end
      send(7'h3D);
      checks++;
      if (bit_cnt !== 4'd0 || err !== 1'b0) begin errors++; $display("FAIL pad_twice cnt=%0d err=%b want 0 0", bit_cnt, err); end
   endtask

   task automatic test_backpressure();
      send(7'h68);
      send(7'h7A);
      in_char = 7'h41;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks += 4;
         if (out_ascii !== 7'h43) begin errors++; $display("FAIL bp_ascii[%0d] got %h want 43", i, out_ascii); end
         if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
         if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b want 0", i, in_ready); end
         if (bit_cnt !== 4'd12) begin errors++; $display("FAIL bp_cnt[%0d] got %0d want 12", i, bit_cnt); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      pop();
      checks++;
      if (bit_cnt !== 4'd5) begin errors++; $display("FAIL bp_pop_cnt got %0d want 5", bit_cnt); end
      send(7'h3D);
   endtask

   task automatic test_illegal();
      send(7'h2A);
      checks += 3;
      if (err !== 1'b1) begin errors++; $display("FAIL illegal_err got %b want 1", err); end
      if (bit_cnt !== 4'd0) begin errors++; $display("FAIL illegal_cnt got %0d want 0", bit_cnt); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got %b want 1", in_ready); end
      send(7'h68);
      send(7'h7A);
      checks += 2;
      if (out_ascii !== 7'h43 || out_valid !== 1'b1) begin errors++; $display("FAIL illegal_hz got %h/%b want 43/1", out_ascii, out_valid); end
      pop();
      if (err !== 1'b1) begin errors++; $display("FAIL illegal_sticky got %b want 1", err); end
      send(7'h3D);
   endtask

   task automatic test_stream();
      logic [101:0] bits = '0;
      logic [6:0] exp;
      int got = 0;
      for (int i = 0; i < 14; i++) bits[101-7*i -: 7] = msg[i];
      for (int k = 0; k < 17; k++) begin
         send(b64(bits[101-6*k -: 6]));
         while (out_valid && got < 20) begin
            exp = got < 14 ? msg[got] : 7'h00;
            checks++;
            if (out_ascii !== exp) begin errors++; $display("FAIL stream_char[%0d] got %h want %h", got, out_ascii, exp); end
            pop();
            got++;
         end
      end
      send(7'h3D);
      checks += 2;
      if (got != 14) begin errors++; $display("FAIL stream_count got %0d want 14", got); end
      if (bit_cnt !== 4'd0) begin errors++; $display("FAIL stream_end_cnt got %0d want 0", bit_cnt); end
   endtask

   task automatic test_url();
      test_reset();
      send(7'h2D);
      checks += 2;
`ifdef BASE64_URL_EN
      if (bit_cnt !== 4'd6) begin errors++; $display("FAIL url_dash_cnt got %0d want 6", bit_cnt); end
      if (err !== 1'b0) begin errors++; $display("FAIL url_dash_err got %b want 0", err); end
      send(7'h5F);
      checks++;
      if (out_ascii !== 7'h7D) begin errors++; $display("FAIL url_pair_ascii got %h want 7d", out_ascii); end
      pop();
`else
      if (bit_cnt !== 4'd0) begin errors++; $display("FAIL url_dash_cnt got %0d want 0", bit_cnt); end
      if (err !== 1'b1) begin errors++; $display("FAIL url_dash_err got %b want 1", err); end
      send(7'h5F);
      checks++;
      if (bit_cnt !== 4'd0) begin errors++; $display("FAIL url_under_cnt got %0d want 0", bit_cnt); end
`endif
      send(7'h3D);
      send(7'h41);
      checks++;
      if (bit_cnt !== 4'd6) begin errors++; $display("FAIL pre_rst_cnt got %0d want 6", bit_cnt); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks += 3;
      if (bit_cnt !== 4'd0) begin errors++; $display("FAIL rst_mid_cnt got %0d want 0", bit_cnt); end
      if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_err got %b want 0", err); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got %b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pad();
      test_backpressure();
      test_illegal();
      test_stream();
      test_url();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
